// File: rtl/am_similarity_engine.sv
// Associative-memory search: accumulates per-class AND-popcount over streamed query segments, then argmax.
// Result NUM_CLASSES+1 cycles after the last beat; query stalls freely, result held until result_ready.
module am_similarity_engine #(
    parameter  int NUM_CLASSES     = 26,
    parameter  int DIMS_PER_CC     = 100,
    parameter  int SEQ_CYCLE_COUNT = 10,
    localparam int SCORE_W         = $clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1),
    localparam int IDX_W           = $clog2(NUM_CLASSES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    input  logic [NUM_CLASSES-1:0][SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] binary_class_hvs,
    input  logic                query_seg_valid,
    input  logic [DIMS_PER_CC-1:0] query_seg,
    output logic                query_seg_ready,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [IDX_W-1:0]    pred_class,
    output logic [SCORE_W-1:0]  pred_score,
    output logic                pred_tie
);

    localparam int SEG_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state;
    logic [SEG_W-1:0]   seg_ctr;
    logic [IDX_W-1:0]   scan_idx;
    logic [SCORE_W-1:0] score   [NUM_CLASSES];
    logic [SCORE_W-1:0] seg_pop [NUM_CLASSES];

    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            seg_pop[i] = '0;
            for (int b = 0; b < DIMS_PER_CC; b++) begin
                seg_pop[i] = seg_pop[i]
                           + SCORE_W'(binary_class_hvs[i][seg_ctr][b] & query_seg[b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state           <= S_IDLE;
            seg_ctr         <= '0;
            scan_idx        <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) score[i] <= '0;
            busy            <= 1'b0;
            query_seg_ready <= 1'b0;
            result_valid    <= 1'b0;
            pred_class      <= '0;
            pred_score      <= '0;
            pred_tie        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) score[i] <= '0;
                        seg_ctr         <= '0;
                        scan_idx        <= '0;
                        state           <= S_ACCUM;
                        busy            <= 1'b1;
                        query_seg_ready <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (query_seg_valid && query_seg_ready) begin
                        for (int i = 0; i < NUM_CLASSES; i++) score[i] <= score[i] + seg_pop[i];
                        if (seg_ctr == SEG_W'(SEQ_CYCLE_COUNT-1)) begin
                            seg_ctr         <= '0;
                            state           <= S_SCAN;
                            query_seg_ready <= 1'b0;
                        end else begin
                            seg_ctr <= seg_ctr + 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    // pred_* double as the running best; scan_idx==0 marks the seeding cycle
                    if (scan_idx == '0) begin
                        pred_class <= '0;
                        pred_score <= score[0];
                        pred_tie   <= 1'b0;
                        scan_idx   <= IDX_W'(1);
                    end else begin
                        if (score[scan_idx] > pred_score) begin
                            pred_class <= scan_idx;
                            pred_score <= score[scan_idx];
                            pred_tie   <= 1'b0;
                        end else if (score[scan_idx] == pred_score) begin
                            pred_tie <= 1'b1;
                        end
                        if (scan_idx == IDX_W'(NUM_CLASSES-1)) begin
                            scan_idx     <= '0;
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_similarity_engine.sv
// Bench for am_similarity_engine: default-size instance for latency, small instance for scoring/argmax/flow.
module tb_am_similarity_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic                     a_rst, a_start, a_abort, a_busy, a_valid, a_ready, a_rv, a_rdy, a_tie;
    logic [25:0][9:0][99:0]   a_hvs;
    logic [99:0]              a_seg;
    logic [4:0]               a_cls;
    logic [9:0]               a_score;

    // small instance: 4 classes, 8-bit segments, 2 segments
    logic                     b_rst, b_start, b_abort, b_busy, b_valid, b_ready, b_rv, b_rdy, b_tie;
    logic [3:0][1:0][7:0]     b_hvs;
    logic [7:0]               b_seg;
    logic [1:0]               b_cls;
    logic [4:0]               b_score;

    am_similarity_engine dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort), .busy(a_busy),
        .binary_class_hvs(a_hvs), .query_seg_valid(a_valid), .query_seg(a_seg),
        .query_seg_ready(a_ready), .result_valid(a_rv), .result_ready(a_rdy),
        .pred_class(a_cls), .pred_score(a_score), .pred_tie(a_tie)
    );

    am_similarity_engine #(.NUM_CLASSES(4), .DIMS_PER_CC(8), .SEQ_CYCLE_COUNT(2)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort), .busy(b_busy),
        .binary_class_hvs(b_hvs), .query_seg_valid(b_valid), .query_seg(b_seg),
        .query_seg_ready(b_ready), .result_valid(b_rv), .result_ready(b_rdy),
        .pred_class(b_cls), .pred_score(b_score), .pred_tie(b_tie)
    );

    typedef struct {
        int cls;
        int score;
        int tie;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [3:0][1:0][7:0] hv, input logic [1:0][7:0] q);
        int   sc[4];
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            sc[c] = 0;
            for (int s = 0; s < 2; s++) sc[c] += $countones(hv[c][s] & q[s]);
        end
        e.cls = 0; e.score = sc[0]; e.tie = 0;
        for (int c = 1; c < 4; c++) begin
            if (sc[c] > e.score) begin
                e.cls = c; e.score = sc[c]; e.tie = 0;
            end else if (sc[c] == e.score) begin
                e.tie = 1;
            end
        end
        return e;
    endfunction

    task automatic b_start_pulse();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    task automatic b_beat(input string tag, input logic [7:0] seg);
        check({tag, "_rdy"}, b_ready, 1);
        b_seg   = seg;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_seg   = 8'h00;
    endtask

    task automatic b_search(input string tag, input logic [1:0][7:0] q);
        exp_q.push_back(model(b_hvs, q));
        b_start_pulse();
        b_beat(tag, q[0]);
        b_beat(tag, q[1]);
    endtask

    task automatic b_wait_rv(input string tag, output bit ok);
        int n = 0;
        while (!b_rv && n < 100) begin
            tick();
            n++;
        end
        ok = b_rv;
        if (!ok) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic b_result(input string tag, input int stall);
        bit   ok;
        exp_t e;
        b_wait_rv(tag, ok);
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (!ok) return;
        for (int k = 0; k <= stall; k++) begin
            check({tag, "_rv"},    b_rv,    1);
            check({tag, "_cls"},   b_cls,   e.cls);
            check({tag, "_score"}, b_score, e.score);
            check({tag, "_tie"},   b_tie,   e.tie);
            if (k == stall) b_rdy = 1'b1;
            tick();
        end
        b_rdy = 1'b0;
        check({tag, "_idle_busy"}, b_busy, 0);
        check({tag, "_idle_rv"},   b_rv,   0);
    endtask

    task automatic b_all_zero(input string tag);
        check({tag, "_busy"},  b_busy,  0);
        check({tag, "_rdy"},   b_ready, 0);
        check({tag, "_rv"},    b_rv,    0);
        check({tag, "_cls"},   b_cls,   0);
        check({tag, "_score"}, b_score, 0);
        check({tag, "_tie"},   b_tie,   0);
    endtask

    logic [1:0][7:0] q_ones;
    logic [1:0][7:0] q_mix;

    initial begin
        bit   ok;
        int   lat;
        exp_t e;

        a_rst = 1; a_start = 0; a_abort = 0; a_valid = 0; a_seg = '0; a_rdy = 0; a_hvs = '0;
        b_rst = 1; b_start = 0; b_abort = 0; b_valid = 0; b_seg = '0; b_rdy = 0;
        b_hvs[0] = {8'h0F, 8'h00};
        b_hvs[1] = {8'hFF, 8'h01};
        b_hvs[2] = {8'hF0, 8'hF0};
        b_hvs[3] = 16'h0000;
        q_ones = 16'hFFFF;
        q_mix  = {8'hF0, 8'h01};
        tick(); tick();
        a_rst = 0; b_rst = 0;

        check("rst_a_busy",  a_busy,  0);
        check("rst_a_rdy",   a_ready, 0);
        check("rst_a_rv",    a_rv,    0);
        check("rst_a_cls",   a_cls,   0);
        check("rst_a_score", a_score, 0);
        check("rst_a_tie",   a_tie,   0);
        b_all_zero("rst_b");

        // test 1: all-zero class HVs, latency from last beat
        e.cls = 0; e.score = 0; e.tie = 1;
        exp_q.push_back(e);
        a_start = 1; tick(); a_start = 0;
        a_seg = '1;
        for (int s = 0; s < 10; s++) begin
            check("t1_rdy", a_ready, 1);
            a_valid = 1;
            tick();
        end
        a_valid = 0;
        lat = 1;
        while (!a_rv && lat < 200) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, 27);
        e = exp_q.pop_front();
        check("t1_cls",   a_cls,   e.cls);
        check("t1_score", a_score, e.score);
        check("t1_tie",   a_tie,   e.tie);
        a_rdy = 1; tick(); a_rdy = 0;
        check("t1_idle", a_busy, 0);

        // test 2: distinct scores 4,9,8,0, plus a mixed query that exercises segment order
        b_search("t2", q_ones);
        b_result("t2", 0);
        b_search("t2m", q_mix);
        b_result("t2m", 0);

        // test 3: tie on the maximum, lowest index wins
        b_hvs[2] = {8'hFF, 8'h01};
        b_search("t3", q_ones);
        b_result("t3", 0);
        b_hvs[2] = {8'hF0, 8'hF0};

        // test 4: gaps between beats, result held under backpressure
        exp_q.push_back(model(b_hvs, q_ones));
        b_start_pulse();
        b_beat("t4", 8'hFF);
        b_seg = 8'hFF;
        tick(); tick();
        check("t4_gap_rdy", b_ready, 1);
        b_beat("t4", 8'hFF);
        b_result("t4", 5);

        // test 5: abort mid-accumulation, start in the same cycle is ignored
        b_start_pulse();
        b_beat("t5a", 8'hFF);
        b_abort = 1; b_start = 1;
        tick();
        b_abort = 0; b_start = 0;
        check("t5_abort_busy", b_busy,  0);
        check("t5_abort_rdy",  b_ready, 0);
        tick();
        check("t5_no_start", b_busy, 0);
        b_search("t5", q_ones);
        b_result("t5", 0);

        // test 6: reset in SCAN, reset in DONE, valid ignored in IDLE
        b_start_pulse();
        b_beat("t6s", 8'hFF);
        b_beat("t6s", 8'hFF);
        tick(); tick();
        check("t6_in_scan", b_busy, 1);
        b_rst = 1; tick(); b_rst = 0;
        b_all_zero("t6_scan_rst");

        b_start_pulse();
        b_beat("t6d", 8'hFF);
        b_beat("t6d", 8'hFF);
        b_wait_rv("t6d", ok);
        check("t6_done_score", b_score, 9);
        b_rst = 1; tick(); b_rst = 0;
        b_all_zero("t6_done_rst");

        b_seg = 8'hFF; b_valid = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_idle_rdy",  b_ready, 0);
            check("t6_idle_busy", b_busy,  0);
        end
        b_valid = 0;
        b_search("t6", q_ones);
        b_result("t6", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/am_similarity_engine.md
Name: am_similarity_engine

Overview:
- Sequential associative-memory search for the sparse HDC classifier.
- Consumes a query hypervector one segment per accepted beat and ANDs each segment with the matching segment of every class hypervector.
- Accumulates a per-class popcount (overlap score), then runs a sequential argmax to produce the predicted class.
- Generalises the fixed 26-class / 10-segment AND array to parametrised class count, segment width and segment count, and adds handshakes, accumulation and classification.

Parameters:
- NUM_CLASSES, 26, number of class hypervectors (≥2)
- DIMS_PER_CC, 100, bits per query segment per beat
- SEQ_CYCLE_COUNT, 10, segments per hypervector (≥1)
- SCORE_W, $clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1), score accumulator width (derived, not overridden)
- IDX_W, $clog2(NUM_CLASSES), class index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a search; accepted only in IDLE
- abort  in  1  synchronous return to IDLE; all scores cleared
- busy  out  1  high in every state except IDLE
- binary_class_hvs  in  [NUM_CLASSES] x [SEQ_CYCLE_COUNT][DIMS_PER_CC]  class HVs; must stay stable while busy
- query_seg_valid  in  1  query segment present
- query_seg  in  DIMS_PER_CC  current query segment, in order 0..SEQ_CYCLE_COUNT-1
- query_seg_ready  out  1  engine accepts a segment this cycle
- result_valid  out  1  prediction available
- result_ready  in  1  consumer takes the prediction
- pred_class  out  IDX_W  index of the best class
- pred_score  out  SCORE_W  overlap score of the best class
- pred_tie  out  1  another class had a score equal to pred_score

Behaviour:
- Reset: state = IDLE. seg_ctr, scan_idx and all scores = 0. All outputs = 0, including busy, query_seg_ready, result_valid, pred_class, pred_score and pred_tie.
- Reset and abort have equal effect in every state and override all other inputs, including a start or beat in the same cycle.
- IDLE:
  - start=1 clears all scores and seg_ctr, then moves to ACCUM next cycle.
  - query_seg_valid is ignored in IDLE.
- ACCUM:
  - query_seg_ready = 1.
  - On a beat (valid & ready), for each class i: score[i] += popcount(binary_class_hvs[i][seg_ctr] & query_seg), then seg_ctr++.
  - On the beat where seg_ctr == SEQ_CYCLE_COUNT-1, seg_ctr resets to 0 and the state moves to SCAN.
  - Any number of idle cycles between beats is allowed.
  - The popcount is purely combinational and registered into the score in the same cycle. A score never overflows: its maximum is DIMS_PER_CC*SEQ_CYCLE_COUNT.
- SCAN:
  - query_seg_ready = 0.
  - First cycle: best_idx = 0, best_score = score[0], tie = 0, scan_idx = 1.
  - Each following cycle compares score[scan_idx] with best_score:
    - strictly greater: replace best_idx/best_score and clear tie;
    - equal: set tie, keep best_idx (lowest index wins);
    - then scan_idx++.
  - After comparing index NUM_CLASSES-1, move to DONE.
  - SCAN lasts exactly NUM_CLASSES cycles.
- DONE:
  - result_valid = 1.
  - pred_class, pred_score and pred_tie are registered and stable while result_valid=1 && result_ready=0.
  - On result_ready=1, return to IDLE next cycle and drop result_valid. Outputs keep their last values but are valid only with result_valid.
  - start is ignored in DONE.
- Latency: last accepted beat at cycle T gives result_valid=1 at cycle T+NUM_CLASSES+1.
- Throughput: one search per SEQ_CYCLE_COUNT + NUM_CLASSES + 2 cycles minimum, with start asserted the cycle after the handoff.

Test Plan:
1. Defaults; all class HVs zero; start, then 10 beats of all-ones query -> pred_class=0, pred_score=0, pred_tie=1; result_valid 27 cycles after the last beat.
2. NUM_CLASSES=4, DIMS_PER_CC=8, SEQ_CYCLE_COUNT=2. Class HVs:
   - class0 = {8'h0F, 8'h00}
   - class1 = {8'hFF, 8'h01}
   - class2 = {8'hF0, 8'hF0}
   - class3 = 0
   Query {8'hFF, 8'hFF} -> scores 4, 9, 8, 0; pred_class=1, pred_score=9, pred_tie=0.
3. Same setup as test 2, but class2 = {8'hFF, 8'h01} -> pred_class=1, pred_tie=1 (lowest index wins).
4. query_seg_valid toggled 1,0,0,1 with result_ready held 0 for 5 cycles -> only 2 beats counted, same result as test 2. Outputs stable while stalled; IDLE one cycle after result_ready=1.
5. abort after the first beat, then a fresh start with the test 2 query -> scores restart from 0 and the result is identical to test 2. A start in the same cycle as abort is ignored.
6. rst asserted in SCAN and again in DONE -> next cycle busy=0, result_valid=0, query_seg_ready=0, pred_* = 0; query_seg_valid in IDLE produces no ready and no score change.
